// File: rtl/jtdd2_mcu_busctl.sv
// jtdd2_mcu_busctl: arbitrates the 1 kB sub-CPU shared RAM for the
// main CPU (halt/ack handshake, main wait, idle release) and times
// the sub-CPU NMI so it never lands while the sub bus is held.
// Ports: clk, rst_n (async, active-low), cen (main clock enable),
//   main_cs, nmi_req in; main_wait_n, mcu_halt, mcu_nmi_set,
//   granted, tout out; mcu_ban (sub bus ack, active-low) in.
// Params: HOLD_CYC idle cen cycles before release (1..255),
//   TOUT_CYC ack watchdog length (1..255).
// Option: define JTDD2_BUSCTL_TIMEOUT_EN to build the REQ watchdog
//   and the sticky tout flag; otherwise REQ waits forever, tout=0.
module jtdd2_mcu_busctl #(
  parameter int HOLD_CYC = 16,
  parameter int TOUT_CYC = 200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cen,
  input  logic main_cs,
  input  logic nmi_req,
  output logic main_wait_n,
  output logic mcu_halt,
  input  logic mcu_ban,
  output logic mcu_nmi_set,
  output logic granted,
  output logic tout
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    HOLD,
    REL
  } state_t;

  localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC);
  localparam logic [7:0] TOUT_LIM = 8'(TOUT_CYC - 1);

  state_t     state;
  state_t     state_nx;
  logic [7:0] cnt;
  logic [7:0] cnt_nx;
  logic       nmi_last;
  logic       nmi_pend;
  logic       pend_nx;
  logic       nmi_edge;
  logic       nmi_srv;
  logic       wt_done;
  logic       halt_nx;
  logic       wait_nx;
  logic       gnt_nx;
`ifdef JTDD2_BUSCTL_TIMEOUT_EN
  logic       to_hit;
`endif

  always_comb begin
    nmi_edge = nmi_req & ~nmi_last;
    wt_done  = (cnt == TOUT_LIM);
    state_nx = state;
    cnt_nx   = cnt;
    nmi_srv  = 1'b0;
`ifdef JTDD2_BUSCTL_TIMEOUT_EN
    to_hit   = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // main access wins over a pending NMI
        if (main_cs) begin
          state_nx = REQ;
          cnt_nx   = '0;
        end else if (nmi_pend && mcu_ban) begin
          nmi_srv = 1'b1;
        end
      end
      REQ: begin
        if (!mcu_ban) begin
          state_nx = GRANT;
        end else if (!wt_done) begin
          cnt_nx = cnt + 8'd1;
        end
`ifdef JTDD2_BUSCTL_TIMEOUT_EN
        else begin
          state_nx = REL;
          to_hit   = 1'b1;
        end
`endif
      end
      GRANT: begin
        if (!main_cs) begin
          state_nx = HOLD;
          cnt_nx   = HOLD_LD;
        end
      end
      HOLD: begin
        if (main_cs) begin
          state_nx = GRANT;
        end else if (cnt == 8'd0) begin
          state_nx = REL;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      REL: begin
        if (mcu_ban) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    // a new edge in the service cycle keeps the flag armed
    pend_nx = nmi_edge | (nmi_pend & ~nmi_srv);

    halt_nx = state_nx inside {REQ, GRANT, HOLD};
    gnt_nx  = state_nx inside {GRANT, HOLD};

    // outside the owned states, stall whenever main touches RAM
    unique case (state_nx)
      REQ:       wait_nx = 1'b0;
      GRANT:     wait_nx = 1'b1;
      HOLD:      wait_nx = 1'b1;
      default:   wait_nx = ~main_cs;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      nmi_last    <= 1'b0;
      nmi_pend    <= 1'b0;
      main_wait_n <= 1'b1;
      mcu_halt    <= 1'b0;
      mcu_nmi_set <= 1'b0;
      granted     <= 1'b0;
    end else if (cen) begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      nmi_last    <= nmi_req;
      nmi_pend    <= pend_nx;
      main_wait_n <= wait_nx;
      mcu_halt    <= halt_nx;
      mcu_nmi_set <= nmi_srv;
      granted     <= gnt_nx;
    end
  end

`ifdef JTDD2_BUSCTL_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tout <= 1'b0;
    end else if (cen) begin
      tout <= tout | to_hit;
    end
  end
`else
  assign tout = 1'b0;
`endif

endmodule

// File: tb/tb_jtdd2_mcu_busctl.sv
// tb_jtdd2_mcu_busctl: scoreboard bench for jtdd2_mcu_busctl.
// Model predicts outputs per cen edge; monitor compares after edge.
module tb_jtdd2_mcu_busctl;

  localparam int HOLD = 16;
  localparam int TOUT = 200;

  logic clk;
  logic rst_n;
  logic cen;
  logic main_cs;
  logic nmi_req;
  logic main_wait_n;
  logic mcu_halt;
  logic mcu_ban;
  logic mcu_nmi_set;
  logic granted;
  logic tout;

  jtdd2_mcu_busctl #(
    .HOLD_CYC(HOLD),
    .TOUT_CYC(TOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cen(cen),
    .main_cs(main_cs),
    .nmi_req(nmi_req),
    .main_wait_n(main_wait_n),
    .mcu_halt(mcu_halt),
    .mcu_ban(mcu_ban),
    .mcu_nmi_set(mcu_nmi_set),
    .granted(granted),
    .tout(tout)
  );

  typedef struct packed {
    logic wait_n;
    logic halt;
    logic nmi;
    logic gnt;
    logic to;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  localparam int P_FREE = 0;
  localparam int P_ASK  = 1;
  localparam int P_OWN  = 2;
  localparam int P_LING = 3;
  localparam int P_BACK = 4;

  int   ph;
  int   ask_n;
  int   ling_n;
  bit   pend;
  bit   prev_nr;
  bit   m_to;
  exp_t e;

  bit   never_ack;
  int   ack_dly;
  int   resp_cnt;

`ifdef JTDD2_BUSCTL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph      = P_FREE;
    ask_n   = 0;
    ling_n  = 0;
    pend    = 1'b0;
    prev_nr = 1'b0;
    m_to    = 1'b0;
    e       = '{wait_n: 1'b1, halt: 1'b0, nmi: 1'b0, gnt: 1'b0, to: 1'b0};
  endtask

  // one cen edge of the bus-sharing rules
  task automatic model_step(input bit cs, input bit nr, input bit ban);
    bit rise;
    bit serve;
    rise    = nr && !prev_nr;
    prev_nr = nr;
    serve   = 1'b0;
    case (ph)
      P_FREE: begin
        if (cs) begin
          ph    = P_ASK;
          ask_n = 0;
        end else if (pend && ban) begin
          serve = 1'b1;
        end
      end
      P_ASK: begin
        ask_n++;
        if (!ban) ph = P_OWN;
        else if (TO_EN && ask_n == TOUT) begin
          ph   = P_BACK;
          m_to = 1'b1;
        end
      end
      P_OWN: begin
        if (!cs) begin
          ph     = P_LING;
          ling_n = 0;
        end
      end
      P_LING: begin
        if (cs) ph = P_OWN;
        else begin
          ling_n++;
          if (ling_n == HOLD + 1) ph = P_BACK;
        end
      end
      default: begin
        if (ban) ph = P_FREE;
      end
    endcase
    pend     = rise || (pend && !serve);
    e.nmi    = serve;
    e.halt   = (ph == P_ASK) || (ph == P_OWN) || (ph == P_LING);
    e.gnt    = (ph == P_OWN) || (ph == P_LING);
    e.to     = m_to;
    if (ph == P_ASK) e.wait_n = 1'b0;
    else if (e.gnt) e.wait_n = 1'b1;
    else e.wait_n = !cs;
  endtask

  // sub-CPU responder follows the predicted halt with a delay
  task automatic respond();
    logic want;
    want = (e.halt && !never_ack) ? 1'b0 : 1'b1;
    if (mcu_ban != want) begin
      if (resp_cnt <= 0) begin
        mcu_ban  = want;
        resp_cnt = ack_dly;
      end else begin
        resp_cnt--;
      end
    end else begin
      resp_cnt = ack_dly;
    end
  endtask

  task automatic step(input bit c, input bit cs, input bit nr);
    @(negedge clk);
    respond();
    cen     = c;
    main_cs = cs;
    nmi_req = nr;
    if (c) begin
      model_step(cs, nr, mcu_ban);
      q.push_back(e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    cen     = 1'b0;
    main_cs = 1'b0;
    nmi_req = 1'b0;
    mcu_ban = 1'b1;
    #1;
    chk("rst_wait_n", main_wait_n, 1'b1);
    chk("rst_halt", mcu_halt, 1'b0);
    chk("rst_nmi", mcu_nmi_set, 1'b0);
    chk("rst_granted", granted, 1'b0);
    chk("rst_tout", tout, 1'b0);
    q.delete();
    model_reset();
    resp_cnt = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(posedge clk) begin
    if (rst_n && cen) begin
      exp_t x;
      #1;
      if (q.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL scoreboard: got no entry want one at %0t", $time);
      end else begin
        x = q.pop_front();
        chk("main_wait_n", main_wait_n, x.wait_n);
        chk("mcu_halt", mcu_halt, x.halt);
        chk("mcu_nmi_set", mcu_nmi_set, x.nmi);
        chk("granted", granted, x.gnt);
        chk("tout", tout, x.to);
        chk("nmi_safe", mcu_nmi_set & (mcu_halt | ~mcu_ban), 1'b0);
      end
    end
  end

  initial begin
    bit cs_r;
    bit nr_r;
    rst_n     = 1'b1;
    cen       = 1'b0;
    main_cs   = 1'b0;
    nmi_req   = 1'b0;
    mcu_ban   = 1'b1;
    never_ack = 1'b0;
    ack_dly   = 2;
    resp_cnt  = 0;
    model_reset();
    do_reset();

    // basic grant and idle release
    ack_dly = 2;
    repeat (8) step(1, 1, 0);
    repeat (25) step(1, 0, 0);

    // back-to-back: re-access inside the hold window
    for (int k = 0; k < 40 && ph != P_OWN; k++) step(1, 1, 0);
    repeat (5) step(1, 0, 0);
    repeat (4) step(1, 1, 0);
    repeat (25) step(1, 0, 0);

    // NMI raised while owned is deferred
    for (int k = 0; k < 40 && ph != P_OWN; k++) step(1, 1, 0);
    step(1, 1, 1);
    step(1, 1, 0);
    repeat (3) step(1, 1, 0);
    repeat (30) step(1, 0, 0);

    // two edges merge; main access in release beats the NMI
    for (int k = 0; k < 40 && ph != P_OWN; k++) step(1, 1, 0);
    step(1, 1, 1);
    step(1, 1, 0);
    step(1, 1, 1);
    step(1, 1, 0);
    for (int k = 0; k < 40 && ph != P_BACK; k++) step(1, 0, 0);
    for (int k = 0; k < 40 && ph != P_ASK; k++) step(1, 1, 0);
    repeat (10) step(1, 1, 0);
    repeat (35) step(1, 0, 0);

    // ack watchdog
    never_ack = 1'b1;
    repeat (TOUT + 5) step(1, 1, 0);
    never_ack = 1'b0;
    repeat (50) step(1, 0, 0);

    // async reset mid-request drops a pending NMI
    do_reset();
    never_ack = 1'b1;
    repeat (3) step(1, 1, 0);
    step(1, 1, 1);
    step(1, 1, 0);
    do_reset();
    never_ack = 1'b0;
    repeat (20) step(1, 0, 0);

    // randomized traffic
    cs_r = 1'b0;
    nr_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) cs_r = !cs_r;
      if ($urandom_range(0, 29) == 0) nr_r = !nr_r;
      if ($urandom_range(0, 49) == 0) ack_dly = $urandom_range(0, 6);
      step($urandom_range(0, 3) != 0, cs_r, nr_r);
    end
    step(0, 0, 0);
    @(posedge clk);
    #3;
    chk("drain", q.size() == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
